// File: rtl/trace_pkg.sv
// trace_pkg: shared state encoding and entry-width helper for the pipeline trace buffer
package trace_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_POST,
    ST_DONE,
    ST_READ
  } state_t;
  // Each stored entry is {cycle stamp, snapshot word}
  function automatic int entry_w(input int cnt_w, input int data_w);
    return cnt_w + data_w;
  endfunction
endpackage

// File: rtl/trace_ram.sv
// trace_ram: DEPTH x W simple dual-port RAM, one write port and a registered read port.
// Ports: clk, reset (async active-low, clears only the read register),
//        we/waddr/wdata write port, re/raddr read request, rdata registered read data.
module trace_ram #(
  parameter int DEPTH = 16,
  parameter int W     = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);
  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] rdata_q;
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end
  // Read data holds when re is low so a stalled consumer sees a stable entry
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rdata_q <= '0;
    else if (re) rdata_q <= mem[raddr];
  end
  assign rdata = rdata_q;
endmodule

// File: rtl/pipeline_trace_buffer.sv
// pipeline_trace_buffer: circular trace capture of pipeline snapshots with trigger, post-trigger window and valid/ready drain.
// Ports: clk, reset (async active-low), clear (sync abort), arm, snap_valid/snap_data capture input,
//        trig/post_cnt trigger control, rd_ready/rd_valid/rd_data/rd_stamp/rd_last drain port,
//        armed/triggered status, fill (entries held), cycle_cnt (free-running stamp counter).
module pipeline_trace_buffer
  import trace_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     arm,
  input  logic                     snap_valid,
  input  logic [DATA_W-1:0]        snap_data,
  input  logic                     trig,
  input  logic [$clog2(DEPTH)-1:0] post_cnt,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [DATA_W-1:0]        rd_data,
  output logic [CNT_W-1:0]         rd_stamp,
  output logic                     rd_last,
  output logic                     armed,
  output logic                     triggered,
  output logic [$clog2(DEPTH):0]   fill,
  output logic [CNT_W-1:0]         cycle_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = entry_w(CNT_W, DATA_W);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_F = (AW+1)'(1);
  localparam logic [AW-1:0] ONE_A = AW'(1);

  state_t state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rem_q, rem_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] fill_q, fill_d;
  logic [AW:0] left_q, left_d;
  logic rd_valid_q, rd_valid_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic cap, we, re;
  logic [AW-1:0] raddr, oldest;
  logic [EW-1:0] rdata;

  trace_ram #(.DEPTH(DEPTH), .W(EW)) u_ram (
    .clk  (clk),
    .reset(reset),
    .we   (we),
    .waddr(wr_ptr_q),
    .wdata({cycle_cnt_q, snap_data}),
    .re   (re),
    .raddr(raddr),
    .rdata(rdata)
  );

  // When full, the low bits of fill are zero, so oldest equals wr_ptr (the next slot to be overwritten)
  assign oldest = wr_ptr_q - fill_q[AW-1:0];
  assign cap = !clear && snap_valid && (state_q == ST_ARMED || state_q == ST_POST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rem_q       <= '0;
      rd_ptr_q    <= '0;
      fill_q      <= '0;
      left_q      <= '0;
      rd_valid_q  <= 1'b0;
      cycle_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rem_q       <= rem_d;
      rd_ptr_q    <= rd_ptr_d;
      fill_q      <= fill_d;
      left_q      <= left_d;
      rd_valid_q  <= rd_valid_d;
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    rd_ptr_d    = rd_ptr_q;
    left_d      = left_q;
    rd_valid_d  = rd_valid_q;
    cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
    we          = cap;
    wr_ptr_d    = cap ? wr_ptr_q + ONE_A : wr_ptr_q;
    fill_d      = (cap && fill_q != FULL) ? fill_q + ONE_F : fill_q;
    re          = 1'b0;
    raddr       = rd_ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (arm) begin
          wr_ptr_d = '0;
          fill_d   = '0;
          state_d  = ST_ARMED;
        end
      end
      ST_ARMED: begin
        // post_cnt is clog2(DEPTH) bits wide, so it can never exceed DEPTH-1 and needs no explicit clamp
        if (trig) begin
          rem_d   = post_cnt;
          state_d = (post_cnt == '0) ? ST_DONE : ST_POST;
        end
      end
      ST_POST: begin
        if (snap_valid) begin
          rem_d   = rem_q - ONE_A;
          state_d = (rem_q == ONE_A) ? ST_DONE : ST_POST;
        end
      end
      ST_DONE: begin
        if (fill_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          re         = 1'b1;
          raddr      = oldest;
          rd_ptr_d   = oldest;
          left_d     = fill_q;
          rd_valid_d = 1'b1;
          state_d    = ST_READ;
        end
      end
      ST_READ: begin
        // Prefetch the next entry on acceptance so it is presented on the following cycle
        if (rd_ready) begin
          if (left_q == ONE_F) begin
            rd_valid_d = 1'b0;
            state_d    = ST_IDLE;
          end else begin
            re       = 1'b1;
            raddr    = rd_ptr_q + ONE_A;
            rd_ptr_d = rd_ptr_q + ONE_A;
            left_d   = left_q - ONE_F;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (clear) begin
      state_d    = ST_IDLE;
      fill_d     = '0;
      rd_valid_d = 1'b0;
      re         = 1'b0;
    end
  end

  assign rd_valid  = rd_valid_q;
  assign rd_last   = rd_valid_q && left_q == ONE_F;
  assign rd_stamp  = rdata[EW-1:DATA_W];
  assign rd_data   = rdata[DATA_W-1:0];
  assign armed     = state_q == ST_ARMED || state_q == ST_POST;
  assign triggered = state_q == ST_POST || state_q == ST_DONE || state_q == ST_READ;
  assign fill      = fill_q;
  assign cycle_cnt = cycle_cnt_q;
endmodule
